// File: rtl/mmc_boot_sequencer.sv
// FPGA configuration sequencer for an MMC boot core: pulses PROGRAM, waits for INIT,
// releases the boot core until DONE, and retries on core error or watchdog timeout.
module mmc_boot_sequencer #(
    parameter int PROG_CYCLES = 16,
    parameter int MAX_TRIES   = 3,
    parameter int TO_W        = 20
) (
    input  logic       cclk,
    input  logic       rst,
    input  logic       start,
    input  logic       init_in,
    input  logic       done_in,
    input  logic       core_error,
    output logic       prog_b,
    output logic       core_dis,
    output logic       busy,
    output logic       boot_ok,
    output logic       boot_fail,
    output logic [3:0] attempt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PROG      = 3'd1,
        S_WAIT_INIT = 3'd2,
        S_RUN       = 3'd3,
        S_RETRY     = 3'd4,
        S_OK        = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    localparam logic [TO_W-1:0] TIMER_MAX = '1;
    localparam logic [TO_W-1:0] PROG_LAST = TO_W'(PROG_CYCLES - 1);
    localparam logic [3:0]      LAST_TRY  = 4'(MAX_TRIES);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] timer;
    logic [3:0]      attempt_nxt;
    logic            timeout;
    logic            prog_done;

    assign timeout   = (timer == TIMER_MAX);
    assign prog_done = (timer == PROG_LAST);

    // start is sampled as a plain level: it only matters in IDLE/OK/FAIL and
    // is ignored while a sequence is in flight, so no hold or acknowledge exists.
    always_comb begin
        state_nxt   = state;
        attempt_nxt = attempt;
        case (state)
            S_IDLE, S_OK, S_FAIL: begin
                if (start) begin
                    attempt_nxt = 4'd1;
                    state_nxt   = S_PROG;
                end
            end
            S_PROG: begin
                if (prog_done) begin
                    state_nxt = S_WAIT_INIT;
                end
            end
            S_WAIT_INIT: begin
                if (init_in) begin
                    state_nxt = S_RUN;
                end else if (timeout) begin
                    state_nxt = S_RETRY;
                end
            end
            S_RUN: begin
                // DONE outranks a simultaneous core error: the FPGA is configured.
                if (done_in) begin
                    state_nxt = S_OK;
                end else if (core_error || timeout) begin
                    state_nxt = S_RETRY;
                end
            end
            S_RETRY: begin
                if (attempt >= LAST_TRY) begin
                    state_nxt = S_FAIL;
                end else begin
                    attempt_nxt = attempt + 4'd1;
                    state_nxt   = S_PROG;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            attempt <= 4'd0;
        end else begin
            state   <= state_nxt;
            attempt <= attempt_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (!timeout) begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign prog_b    = (state != S_PROG);
    assign core_dis  = (state != S_RUN);
    assign busy      = (state == S_PROG) || (state == S_WAIT_INIT) ||
                       (state == S_RUN)  || (state == S_RETRY);
    assign boot_ok   = (state == S_OK);
    assign boot_fail = (state == S_FAIL);
    assign state_dbg = state;

endmodule

// File: tb/tb_mmc_boot_sequencer.sv
// Bench for mmc_boot_sequencer: expected output phases (value + duration) are queued by a
// phase-level model as stimulus is issued; a monitor run-length encodes the outputs and compares.
`timescale 1ns/1ps
module tb_mmc_boot_sequencer;
    localparam int PROG_CYCLES = 16;
    localparam int MAX_TRIES   = 3;
    localparam int EV_DONE = 0, EV_ERR = 1, EV_BOTH = 2, EV_TMO = 3, EV_RST = 4;

    // clock / reset
    logic cclk = 1'b0;
    always #5 cclk = ~cclk;

    logic rst, sel, start, init_in, done_in, core_error;
    logic rst_a, rst_b;
    logic prog_b_a, core_dis_a, busy_a, boot_ok_a, boot_fail_a;
    logic prog_b_b, core_dis_b, busy_b, boot_ok_b, boot_fail_b;
    logic [3:0] attempt_a, attempt_b;
    logic [2:0] state_dbg_a, state_dbg_b;
    logic [8:0] obs;

    // Instance a keeps the default 20-bit watchdog; instance b uses a 4-bit one.
    assign rst_a = rst | sel;
    assign rst_b = rst | ~sel;
    assign obs = sel ? {prog_b_b, core_dis_b, busy_b, boot_ok_b, boot_fail_b, attempt_b}
                     : {prog_b_a, core_dis_a, busy_a, boot_ok_a, boot_fail_a, attempt_a};

    mmc_boot_sequencer #(.PROG_CYCLES(PROG_CYCLES), .MAX_TRIES(MAX_TRIES), .TO_W(20)) dut_a (
        .cclk(cclk), .rst(rst_a), .start(start), .init_in(init_in), .done_in(done_in),
        .core_error(core_error), .prog_b(prog_b_a), .core_dis(core_dis_a), .busy(busy_a),
        .boot_ok(boot_ok_a), .boot_fail(boot_fail_a), .attempt(attempt_a), .state_dbg(state_dbg_a)
    );

    mmc_boot_sequencer #(.PROG_CYCLES(PROG_CYCLES), .MAX_TRIES(MAX_TRIES), .TO_W(4)) dut_b (
        .cclk(cclk), .rst(rst_b), .start(start), .init_in(init_in), .done_in(done_in),
        .core_error(core_error), .prog_b(prog_b_b), .core_dis(core_dis_b), .busy(busy_b),
        .boot_ok(boot_ok_b), .boot_fail(boot_fail_b), .attempt(attempt_b), .state_dbg(state_dbg_b)
    );

    // scoreboard state
    logic [24:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [8:0]  pend_v;
    logic [15:0] pend_len;
    bit          pend_valid = 1'b0;
    int          model_cycles = 0;
    bit          drv_done = 1'b0;
    logic [8:0]  now_v;
    int          cur_tow;
    int          plan_d[MAX_TRIES];
    int          plan_r[MAX_TRIES];
    int          plan_e[MAX_TRIES];

    // observable output phases: {prog_b, core_dis, busy, boot_ok, boot_fail, attempt}
    function automatic logic [8:0] mk(input bit pb, input bit cd, input bit bz,
                                      input bit ok, input bit fl, input int att);
        logic [3:0] a4;
        a4 = att[3:0];
        return {pb, cd, bz, ok, fl, a4};
    endfunction
    function automatic logic [8:0] v_idle(input int a); return mk(1, 1, 0, 0, 0, a); endfunction
    function automatic logic [8:0] v_prog(input int a); return mk(0, 1, 1, 0, 0, a); endfunction
    function automatic logic [8:0] v_wait(input int a); return mk(1, 1, 1, 0, 0, a); endfunction
    function automatic logic [8:0] v_run(input int a);  return mk(1, 0, 1, 0, 0, a); endfunction
    function automatic logic [8:0] v_ok(input int a);   return mk(1, 1, 0, 1, 0, a); endfunction
    function automatic logic [8:0] v_fail(input int a); return mk(1, 1, 0, 0, 1, a); endfunction

    // model: one cycle showing value v; completed phases go to the expected queue
    task automatic model_add(input logic [8:0] v);
        model_cycles++;
        if (!pend_valid) begin
            pend_v = v; pend_len = 16'd1; pend_valid = 1'b1;
        end else if (v == pend_v) begin
            pend_len = pend_len + 16'd1;
        end else begin
            exp_q.push_back({pend_v, pend_len});
            pend_v = v; pend_len = 16'd1;
        end
    endtask

    task automatic check_seg(input logic [8:0] v, input logic [15:0] len);
        logic [24:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL segment: got v=%b len=%0d, expected nothing (queue empty)", v, len);
        end else begin
            e = exp_q.pop_front();
            if (e == {v, len}) n_pass++;
            else $display("FAIL segment: got v=%b len=%0d, expected v=%b len=%0d",
                          v, len, e[24:16], e[15:0]);
        end
    endtask

    // monitor: processes each negedge sample one cycle late so the model is always ahead
    logic [8:0]  prev_v, cur_v;
    logic [15:0] cur_len;
    bit          have_prev = 1'b0;
    bit          cur_valid = 1'b0;
    int          mon_cycles = 0;

    always @(negedge cclk) begin
        if (have_prev && (!drv_done || mon_cycles < model_cycles)) begin
            mon_cycles++;
            if (!cur_valid) begin
                cur_v = prev_v; cur_len = 16'd1; cur_valid = 1'b1;
            end else if (prev_v == cur_v) begin
                cur_len = cur_len + 16'd1;
            end else begin
                check_seg(cur_v, cur_len);
                cur_v = prev_v; cur_len = 16'd1;
            end
        end
        prev_v = obs;
        have_prev = 1'b1;
    end

    // driver tasks: inputs change 1ns after the falling edge
    task automatic step();
        @(negedge cclk);
        #1;
    endtask

    task automatic noise();
        init_in    = 1'($urandom_range(0, 1));
        done_in    = 1'($urandom_range(0, 1));
        core_error = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_cycles(input int n, input logic new_sel);
        for (int i = 0; i < n; i++) begin
            rst = 1'b1; sel = new_sel;
            start = 1'($urandom_range(0, 1));
            noise();
            model_add(now_v);
            now_v = v_idle(0);
            step();
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b0; start = 1'b0;
            noise();
            model_add(now_v);
            step();
        end
    endtask

    task automatic set_plan(input int i, input int d, input int r, input int e);
        plan_d[i] = d; plan_r[i] = r; plan_e[i] = e;
    endtask

    task automatic rand_plan();
        int e;
        for (int i = 0; i < MAX_TRIES; i++) begin
            if (cur_tow <= 4 && $urandom_range(0, 2) == 0) plan_d[i] = -1;
            else plan_d[i] = $urandom_range(0, 5);
            if (cur_tow <= 4) begin
                plan_r[i] = $urandom_range(1, 14);
                plan_e[i] = $urandom_range(0, 4);
            end else begin
                plan_r[i] = $urandom_range(1, 40);
                e = $urandom_range(0, 3);
                plan_e[i] = (e == 3) ? EV_RST : e;
            end
        end
    endtask

    // One boot request from IDLE/OK/FAIL following plan_*; leaves now_v at the terminal phase.
    task automatic boot();
        int a, d, r, e, w, tmax;
        tmax = 1 << cur_tow;
        rst = 1'b0; start = 1'b1; noise();
        model_add(now_v);
        now_v = v_prog(1);
        step();
        a = 1;
        forever begin
            for (int k = 0; k < PROG_CYCLES; k++) begin
                rst = 1'b0; start = 1'($urandom_range(0, 1)); noise();
                model_add(now_v);
                if (k == PROG_CYCLES - 1) now_v = v_wait(a);
                step();
            end
            d = plan_d[a-1];
            w = (d < 0) ? tmax : d + 1;
            for (int i = 0; i < w; i++) begin
                start = 1'($urandom_range(0, 1));
                done_in = 1'($urandom_range(0, 1));
                core_error = 1'($urandom_range(0, 1));
                init_in = (d >= 0 && i == d);
                model_add(now_v);
                if (i == w - 1) now_v = (d < 0) ? v_wait(a) : v_run(a);
                step();
            end
            if (d >= 0) begin
                e = plan_e[a-1];
                r = (e == EV_TMO) ? tmax : plan_r[a-1];
                for (int i = 0; i < r; i++) begin
                    start = 1'($urandom_range(0, 1));
                    init_in = 1'b1; done_in = 1'b0; core_error = 1'b0;
                    if (i == r - 1) begin
                        case (e)
                            EV_DONE: done_in = 1'b1;
                            EV_ERR:  core_error = 1'b1;
                            EV_BOTH: begin done_in = 1'b1; core_error = 1'b1; end
                            EV_RST:  begin rst = 1'b1; start = 1'b1; end
                            default: ;
                        endcase
                    end
                    model_add(now_v);
                    if (i == r - 1) begin
                        if (e == EV_DONE || e == EV_BOTH) now_v = v_ok(a);
                        else if (e == EV_RST) now_v = v_idle(0);
                        else now_v = v_wait(a);
                    end
                    step();
                end
                if (e == EV_DONE || e == EV_BOTH || e == EV_RST) return;
            end
            // single RETRY cycle
            rst = 1'b0; start = 1'($urandom_range(0, 1)); noise();
            model_add(now_v);
            now_v = (a >= MAX_TRIES) ? v_fail(a) : v_prog(a + 1);
            step();
            if (a >= MAX_TRIES) return;
            a++;
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; start = 1'b0; init_in = 1'b0; done_in = 1'b0; core_error = 1'b0;
        cur_tow = 20;
        now_v = v_idle(0);
        step();
        reset_cycles(3, 1'b0);
        idle_cycles(4);
        // nominal: INIT two cycles after PROG ends, DONE after 100 RUN cycles
        set_plan(0, 2, 100, EV_DONE);
        boot(); idle_cycles(5);
        // core error on the first RUN cycle, second attempt nominal
        set_plan(0, 2, 1, EV_ERR); set_plan(1, 2, 100, EV_DONE);
        boot(); idle_cycles(3);
        // DONE and core error together
        set_plan(0, 1, 10, EV_BOTH);
        boot(); idle_cycles(3);
        // reset mid-RUN (with start high), then a fresh boot
        set_plan(0, 0, 50, EV_RST);
        boot(); idle_cycles(3);
        set_plan(0, 3, 20, EV_DONE);
        boot(); idle_cycles(2);
        for (int n = 0; n < 6; n++) begin
            rand_plan(); boot(); idle_cycles($urandom_range(1, 4));
        end
        // switch to the short-watchdog instance
        reset_cycles(2, 1'b1);
        cur_tow = 4;
        idle_cycles(2);
        // INIT never rises: three timed-out attempts then FAIL
        set_plan(0, -1, 1, EV_DONE); set_plan(1, -1, 1, EV_DONE); set_plan(2, -1, 1, EV_DONE);
        boot(); idle_cycles(4);
        // restart straight from FAIL
        set_plan(0, 1, 5, EV_DONE);
        boot(); idle_cycles(3);
        // RUN watchdog timeout, then success
        set_plan(0, 0, 1, EV_TMO); set_plan(1, 2, 7, EV_DONE);
        boot(); idle_cycles(2);
        for (int n = 0; n < 8; n++) begin
            rand_plan(); boot(); idle_cycles($urandom_range(1, 4));
        end
        rst = 1'b0; start = 1'b0;
        model_add(now_v);
        drv_done = 1'b1;
        repeat (3) @(negedge cclk);
        // final report
        n_checks++;
        if (cur_valid && cur_v == pend_v && cur_len == pend_len) n_pass++;
        else $display("FAIL tail_segment: got v=%b len=%0d, expected v=%b len=%0d",
                      cur_v, cur_len, pend_v, pend_len);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL leftover: got %0d unmatched phases, expected 0", exp_q.size());
        n_checks++;
        if (mon_cycles == model_cycles) n_pass++;
        else $display("FAIL cycle_count: got %0d, expected %0d", mon_cycles, model_cycles);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
